// File: rtl/pe_act_queue_if.sv
// pe_act_queue_if: handshake bundle between the network interface / controller /
// computation FSM (master side) and the per-PE activation queue (slave side).
//   push_en/push_idx/push_value : activation delivered by the router
//   queue_clear                 : layer-boundary flush
//   pop_act                     : computation FSM consumes the head entry
//   act_out                     : head entry {idx, value}, zero while empty
//   queue_empty/full/almost_full, count, overflow, underflow : status
interface pe_act_queue_if #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned IDX_WIDTH  = 10,
    parameter int unsigned DEPTH      = 8
);
    logic                          push_en;
    logic [IDX_WIDTH-1:0]          push_idx;
    logic [DATA_WIDTH-1:0]         push_value;
    logic                          queue_clear;
    logic                          pop_act;
    logic [IDX_WIDTH+DATA_WIDTH-1:0] act_out;
    logic                          queue_empty;
    logic                          queue_full;
    logic                          queue_almost_full;
    logic [$clog2(DEPTH):0]        count;
    logic                          overflow;
    logic                          underflow;

    modport master (
        output push_en, push_idx, push_value, queue_clear, pop_act,
        input  act_out, queue_empty, queue_full, queue_almost_full, count,
               overflow, underflow
    );

    modport slave (
        input  push_en, push_idx, push_value, queue_clear, pop_act,
        output act_out, queue_empty, queue_full, queue_almost_full, count,
               overflow, underflow
    );
endinterface

// File: rtl/pe_act_queue.sv
// pe_act_queue: per-PE first-word-fall-through activation queue.
// Buffers (index, value) pairs from the router, optionally drops zero values on
// entry, raises almost-full back-pressure, and flushes on queue_clear.
// Ports:
//   clk : system clock
//   rst : synchronous active-low reset
//   q   : pe_act_queue_if slave modport (push/pop handshake, head entry, status)
// All outputs decode directly from registers.
module pe_act_queue #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned IDX_WIDTH  = 10,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned AF_MARGIN  = 2,
    parameter bit          SKIP_ZERO  = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    pe_act_queue_if.slave  q
);
    localparam int unsigned PtrW  = $clog2(DEPTH);
    localparam int unsigned CntW  = PtrW + 1;
    localparam int unsigned EntW  = IDX_WIDTH + DATA_WIDTH;

    logic [EntW-1:0] mem_q [DEPTH];
    logic [EntW-1:0] mem_d [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            overflow_q, overflow_d;
    logic            underflow_q, underflow_d;

    logic empty, full, zero_skip, push_ok, pop_ok;

    // Occupancy counter is the sole source of empty/full.
    assign empty     = (count_q == '0);
    assign full      = (count_q == CntW'(DEPTH));
    assign zero_skip = SKIP_ZERO && (q.push_value == '0);
    assign pop_ok    = q.pop_act & ~empty;
    // A full queue can still take a push when the head leaves in the same cycle.
    assign push_ok   = q.push_en & ~zero_skip & (~full | pop_ok);

    always_comb begin
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (q.queue_clear) begin
            // Flush wins over push/pop; sticky flags survive a flush.
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                mem_d[wr_ptr_q] = {q.push_idx, q.push_value};
                wr_ptr_d        = wr_ptr_q + PtrW'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            unique case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
            if (q.push_en && !zero_skip && full && !pop_ok) begin
                overflow_d = 1'b1;
            end
            // Set even when a push arrives alongside; that push is still written.
            if (q.pop_act && empty) begin
                underflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage needs no reset; entries are only visible while counted.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign q.act_out           = empty ? '0 : mem_q[rd_ptr_q];
    assign q.queue_empty       = empty;
    assign q.queue_full        = full;
    assign q.queue_almost_full = (count_q >= CntW'(DEPTH - AF_MARGIN));
    assign q.count             = count_q;
    assign q.overflow          = overflow_q;
    assign q.underflow         = underflow_q;
endmodule

// File: tb/tb_pe_act_queue.sv
// tb_pe_act_queue: table-driven vectors plus hand-written corner sequences for
// pe_act_queue; a scoreboard queue holds the entries expected at the head.
module tb_pe_act_queue;
    localparam int unsigned DW    = 16;
    localparam int unsigned IW    = 10;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned AFM   = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pe_act_queue_if #(.DATA_WIDTH(DW), .IDX_WIDTH(IW), .DEPTH(DEPTH)) bus ();

    pe_act_queue #(
        .DATA_WIDTH(DW), .IDX_WIDTH(IW), .DEPTH(DEPTH), .AF_MARGIN(AFM), .SKIP_ZERO(1'b1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .q   (bus)
    );

    typedef struct {
        bit          rst_n;
        bit          clr;
        bit          pe;
        logic [IW-1:0] idx;
        logic [DW-1:0] val;
        bit          pop;
        int          exp_cnt;
        bit          exp_ovf;
        bit          exp_udf;
    } vec_t;

    logic [IW+DW-1:0] sb[$];
    bit ovf_m, udf_m;
    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle, update the scoreboard, then compare after the edge.
    task automatic step(input bit rst_n, input bit clr, input bit pe,
                        input logic [IW-1:0] idx, input logic [DW-1:0] val, input bit pop);
        int  sz;
        bit  pop_v;
        bit  nz;
        rst             = rst_n;
        bus.queue_clear = clr;
        bus.push_en     = pe;
        bus.push_idx    = idx;
        bus.push_value  = val;
        bus.pop_act     = pop;
        sz    = sb.size();
        pop_v = pop && (sz > 0);
        nz    = (val != 0);
        if (!rst_n) begin
            sb.delete();
            ovf_m = 1'b0;
            udf_m = 1'b0;
        end else if (clr) begin
            sb.delete();
        end else begin
            if (pop && sz == 0) udf_m = 1'b1;
            if (pe && nz && sz == DEPTH && !pop_v) ovf_m = 1'b1;
            if (pop_v) void'(sb.pop_front());
            if (pe && nz && (sz < DEPTH || pop_v)) sb.push_back({idx, val});
        end
        @(posedge clk);
        #1;
        chk("act_out", 32'(bus.act_out), (sb.size() > 0) ? 32'(sb[0]) : 32'd0);
        chk("count", 32'(bus.count), 32'(sb.size()));
        chk("empty", 32'(bus.queue_empty), 32'(sb.size() == 0));
        chk("full", 32'(bus.queue_full), 32'(sb.size() == DEPTH));
        chk("almost_full", 32'(bus.queue_almost_full), 32'(sb.size() >= DEPTH - AFM));
        chk("overflow", 32'(bus.overflow), 32'(ovf_m));
        chk("underflow", 32'(bus.underflow), 32'(udf_m));
    endtask

    vec_t vecs[12];

    initial begin
        bus.queue_clear = 1'b0;
        bus.push_en     = 1'b0;
        bus.push_idx    = '0;
        bus.push_value  = '0;
        bus.pop_act     = 1'b0;

        // Reset, basic FIFO order, zero skip.
        vecs[0]  = '{0, 0, 0, 10'd0, 16'h0000, 0, 0, 0, 0};
        vecs[1]  = '{0, 0, 0, 10'd0, 16'h0000, 0, 0, 0, 0};
        vecs[2]  = '{1, 0, 1, 10'd3, 16'h0011, 0, 1, 0, 0};
        vecs[3]  = '{1, 0, 1, 10'd5, 16'h0022, 0, 2, 0, 0};
        vecs[4]  = '{1, 0, 1, 10'd9, 16'h0033, 0, 3, 0, 0};
        vecs[5]  = '{1, 0, 0, 10'd0, 16'h0000, 1, 2, 0, 0};
        vecs[6]  = '{1, 0, 0, 10'd0, 16'h0000, 1, 1, 0, 0};
        vecs[7]  = '{1, 0, 0, 10'd0, 16'h0000, 1, 0, 0, 0};
        vecs[8]  = '{1, 0, 1, 10'd1, 16'h0000, 0, 0, 0, 0};
        vecs[9]  = '{1, 0, 1, 10'd2, 16'h0005, 0, 1, 0, 0};
        vecs[10] = '{1, 0, 1, 10'd4, 16'h0000, 0, 1, 0, 0};
        vecs[11] = '{1, 0, 0, 10'd0, 16'h0000, 1, 0, 0, 0};

        for (int i = 0; i < 12; i++) begin
            step(vecs[i].rst_n, vecs[i].clr, vecs[i].pe, vecs[i].idx, vecs[i].val, vecs[i].pop);
            chk("tbl_count", 32'(bus.count), 32'(vecs[i].exp_cnt));
            chk("tbl_overflow", 32'(bus.overflow), 32'(vecs[i].exp_ovf));
            chk("tbl_underflow", 32'(bus.underflow), 32'(vecs[i].exp_udf));
            if (i == 2) chk("first_head", 32'(bus.act_out), 32'({10'd3, 16'h0011}));
            if (i == 9) chk("zskip_value", 32'(bus.act_out[DW-1:0]), 32'h0005);
        end

        // Fill to full; almost_full from count 6.
        for (int i = 0; i < 8; i++) begin
            step(1, 0, 1, 10'(16 + i), 16'(16'h0100 + i), 0);
            chk("af_at_fill", 32'(bus.queue_almost_full), 32'(i >= 5));
        end
        chk("full_after_8", 32'(bus.queue_full), 32'd1);
        // Ninth push dropped.
        step(1, 0, 1, 10'd99, 16'h0999, 0);
        chk("ovf_after_9th", 32'(bus.overflow), 32'd1);
        chk("head_after_9th", 32'(bus.act_out), 32'({10'd16, 16'h0100}));
        // Push + pop at full: count holds, head advances.
        step(1, 0, 1, 10'd50, 16'h0050, 1);
        chk("full_pp_count", 32'(bus.count), 32'd8);
        chk("full_pp_head", 32'(bus.act_out), 32'({10'd17, 16'h0101}));
        // Pop 3, push 3 across the pointer wrap, then drain in order.
        for (int i = 0; i < 3; i++) step(1, 0, 0, 10'd0, 16'h0000, 1);
        for (int i = 0; i < 3; i++) step(1, 0, 1, 10'(60 + i), 16'(16'h0200 + i), 0);
        chk("wrap_count", 32'(bus.count), 32'd8);
        for (int i = 0; i < 8; i++) step(1, 0, 0, 10'd0, 16'h0000, 1);
        chk("drained_empty", 32'(bus.queue_empty), 32'd1);

        // Push + pop at empty.
        step(1, 0, 1, 10'd7, 16'h0077, 1);
        chk("empty_pp_count", 32'(bus.count), 32'd1);
        chk("empty_pp_udf", 32'(bus.underflow), 32'd1);
        chk("empty_pp_head", 32'(bus.act_out), 32'({10'd7, 16'h0077}));

        // Clear beats a simultaneous push; sticky flags survive.
        for (int i = 0; i < 3; i++) step(1, 0, 1, 10'(70 + i), 16'(16'h0300 + i), 0);
        chk("pre_clear_count", 32'(bus.count), 32'd4);
        step(1, 1, 1, 10'd80, 16'h0400, 0);
        chk("clr_count", 32'(bus.count), 32'd0);
        chk("clr_empty", 32'(bus.queue_empty), 32'd1);
        chk("clr_ovf_kept", 32'(bus.overflow), 32'd1);
        chk("clr_udf_kept", 32'(bus.underflow), 32'd1);

        // Mid-stream reset.
        step(1, 0, 1, 10'd81, 16'h0401, 0);
        step(1, 0, 1, 10'd82, 16'h0402, 0);
        step(0, 0, 0, 10'd0, 16'h0000, 0);
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_ovf", 32'(bus.overflow), 32'd0);
        chk("rst_udf", 32'(bus.underflow), 32'd0);
        step(1, 0, 1, 10'd1, 16'h00ab, 0);
        chk("post_rst_head", 32'(bus.act_out), 32'({10'd1, 16'h00ab}));
        step(1, 0, 0, 10'd0, 16'h0000, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/pe_act_queue.md
# pe_act_queue

Per-PE activation queue between the network interface and the PE computation FSM. It buffers incoming (input-activation index, value) pairs delivered by the router and presents them first-word-fall-through to the computation FSM, which consumes them with `pop_act`. It also drops zero-valued activations on entry, raises back-pressure toward the network interface, and flushes on layer boundaries.

## Interface
- `DATA_WIDTH`, 16: activation value width; matches the PE data bus.
- `IDX_WIDTH`, 10: input activation index width; matches the PE address bus.
- `DEPTH`, 8: entries; power of two, at least 4.
- `AF_MARGIN`, 2: `queue_almost_full` asserts when `count >= DEPTH-AF_MARGIN`; must satisfy `1 <= AF_MARGIN < DEPTH`.
- `SKIP_ZERO`, 1: when 1, pushes with value 0 are discarded.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  synchronous, active-low reset.
- `push_en`  in  1  network interface delivers one activation this cycle.
- `push_idx`  in  IDX_WIDTH  input activation index.
- `push_value`  in  DATA_WIDTH  input activation value.
- `queue_clear`  in  1  synchronous flush; driven from the controller's out-act-clear / layer start.
- `pop_act`  in  1  computation FSM consumes the head entry.
- `act_out`  out  IDX_WIDTH+DATA_WIDTH  head entry `{idx, value}`; idx in the MSBs. Forced to 0 while empty.
- `queue_empty`  out  1  no valid entry.
- `queue_full`  out  1  `count == DEPTH`.
- `queue_almost_full`  out  1  back-pressure to the network interface / router credit.
- `count`  out  $clog2(DEPTH)+1  occupancy.
- `overflow`  out  1  sticky: a push was lost because the queue was full.
- `underflow`  out  1  sticky: a pop arrived while the queue was empty.

## Operation
- Storage: DEPTH-entry register array, write pointer `wr_ptr` and read pointer `rd_ptr`, each $clog2(DEPTH) bits. Pointers wrap naturally from DEPTH-1 to 0. A separate `count` register is the only source of the empty and full status; pointer comparison is not used.
- Push qualification: `push_ok = push_en & ~(SKIP_ZERO & (push_value == 0)) & (~queue_full | pop_ok)`.
  - A push while full is accepted only if a valid pop occurs in the same cycle.
  - A push while full with no pop is dropped and sets `overflow`.
  - A zero-skipped push never sets `overflow`.
- Pop qualification: `pop_ok = pop_act & ~queue_empty`.
  - A pop while empty is ignored and sets `underflow`, including when a push arrives in the same cycle. The pushed entry is still written.
- Count update: +1 on push_ok only, −1 on pop_ok only, unchanged when both or neither occur.
- `queue_clear` has priority over push and pop in the same cycle. It zeroes the pointers and `count` and discards the push. The sticky flags are **not** cleared by `queue_clear`; only `rst` clears them.
- Reset (`rst == 0` at a clk edge):
  - pointers, `count`, `overflow` and `underflow` go to 0;
  - as a result `queue_empty = 1`, `queue_full = 0`, `queue_almost_full = 0` and `act_out = 0`;
  - array contents are don't-care.
  - Reset asserted mid-stream discards all entries; the first push after reset release lands at entry 0.

## Timing
- Push to visible: an entry accepted at edge N appears on `act_out` with `queue_empty = 0` after edge N. The latency is 1 cycle.
- Pop: the head advances at the edge where `pop_ok` is sampled. The next entry, or empty, is visible after that edge.
  - The computation FSM may pop every cycle; sustained throughput is 1 entry per cycle.
- All status outputs (`queue_empty`, `queue_full`, `queue_almost_full`, `count`, flags) are registered or decoded directly from registers. There is no combinational path from `push_en` or `pop_act` to any output.
- The network interface must stop pushing the cycle after it samples `queue_almost_full = 1`. `AF_MARGIN >= 2` covers its one-cycle reaction.

## Test plan
- **Reset / basic FIFO:** hold `rst = 0` 2 cycles, then push (idx 3, val 0x0011), (5, 0x0022), (9, 0x0033) on consecutive cycles.
  - After reset: `queue_empty = 1`, `act_out = 0`.
  - After the first push edge: `act_out = {3, 0x0011}`.
  - Popping three cycles in a row yields the entries in order, then `queue_empty = 1` and `count = 0`.
- **Zero skip:** with `SKIP_ZERO = 1`, push values 0x0000, 0x0005, 0x0000. Required: `count = 1`, `act_out` value = 0x0005, `overflow = 0`.
- **Full / overflow / wrap:** with DEPTH = 8:
  - push 8 entries: `queue_full = 1` and `queue_almost_full = 1` (asserted from count 6);
  - a ninth push is dropped and `overflow = 1`;
  - pop 3, push 3 more: the order is preserved across the pointer wrap.
- **Simultaneous push + pop:**
  - At full, push + pop in the same cycle: `count` stays 8 and the head advances.
  - At empty, push + pop in the same cycle: `count = 1`, `underflow = 1`, and the pushed entry is at the head.
- **Clear priority and mid-stream reset:**
  - With 4 entries, assert `queue_clear` together with `push_en`: `count = 0`, `queue_empty = 1`, sticky flags unchanged.
  - Then push 2 and pulse `rst = 0` for 1 cycle: `count = 0` and flags are 0.
